md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Multiply/divide scheduler and HI/LO owner for the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and holds HI/LO.
- Models multi-cycle latency with a down-counter and busy flag.
- Generates the D-stage stall for any md-class instruction (incl. mfhi/mflo) while the unit is busy or starting.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage md instruction valid this cycle.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- A  input  32  forwarded rs value in E.
- B  input  32  forwarded rt value in E.
- flush  input  1  synchronous cancel of an in-flight mult/div.
- md_in_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  a mult/div is in flight.
- hi  output  32  current HI (feeds mfhi in E).
- lo  output  32  current LO (feeds mflo in E).
- stall_md  output  1  D-stage stall request; ORed with the hazard stall outside this block.

Behaviour:
- Reset (async, reset=0): hi=0, lo=0, busy=0, counter=0, pending HI/LO=0. stall_md follows the combinational rule below.
- Registers: 4-bit counter cnt; 32-bit pending_hi and pending_lo. busy = (cnt != 0).
- Start of mult/div (start=1, md_op 1..4, busy=0) at edge t:
  - Compute the result from A and B and store it in pending_hi/pending_lo.
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
  - busy is 1 in the N cycles after edge t.
- Countdown: at each edge with cnt > 1, cnt decrements. At the edge with cnt == 1: hi<=pending_hi, lo<=pending_lo, cnt<=0.
  - New HI/LO are visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product; hi = [63:32], lo = [31:0].
  - multu: same, unsigned.
  - div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned.
  - Divide by zero: pending = current hi/lo, so HI/LO are unchanged at completion; busy timing is unchanged.
- mthi/mtlo (start=1, md_op 5/6, busy=0): hi<=A or lo<=A at the same edge; no busy cycles.
- start with busy=1: the operation is ignored and state is unaffected. The D-stage stall prevents this case; the bench flags it as an error.
- md_op 0 or 7 with start=1: no-op.
- flush=1 at an edge:
  - cnt<=0 and pending values are discarded; hi/lo keep pre-op values.
  - flush has priority over a same-edge completion and over a same-edge start.
- stall_md = md_in_D & (busy | (start & md_op in 1..4)), combinational.
  - A dependent mfhi in D waits until the cycle after busy falls, then sees the updated hi via E.
- mfhi/mflo reads are combinational from hi/lo. There is no bypass of pending values.
- Reset mid-operation: everything returns to reset values immediately; no HI/LO write occurs.

Test Plan:
- mult A=0xFFFFFFFE(-2), B=3 -> busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=0 -> hi/lo unchanged after 10 busy cycles.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> hi/lo updated at each edge, busy never asserts.
- md_in_D=1 during the start cycle and all 5 busy cycles of a mult -> stall_md=1 for 6 cycles, 0 on the cycle busy falls. md_in_D=0 -> stall_md stays 0.
- flush asserted on the 3rd busy cycle of a div -> busy drops next cycle, hi/lo equal pre-div values. Flush on the same edge as completion -> no update.
- reset pulled low during busy cycle 2 -> immediate busy=0, hi=lo=0. A start attempted while busy -> ignored; completion yields the first op's result.

Source files
------------

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module   : md_sched
// Purpose  : Multiply/divide scheduler and HI/LO owner. Computes mult/div
//            results at issue, then releases them after a fixed busy latency.
// Revision : 1.0 - initial release
// ============================================================================
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    input  logic        md_in_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic               w_is_muldiv;
    logic               w_busy;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_quot_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quot_u;
    logic        [31:0] w_rem_u;
    logic               w_div_zero;

    assign w_busy      = (cnt_q != 4'd0);
    assign w_is_muldiv = (md_op >= c_op_mult) && (md_op <= c_op_divu);
    assign w_div_zero  = (B == 32'd0);

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};
    // Divider outputs are only consumed when B is nonzero.
    assign w_quot_s = w_div_zero ? 32'sd0 : $signed(A) / $signed(B);
    assign w_rem_s  = w_div_zero ? 32'sd0 : $signed(A) % $signed(B);
    assign w_quot_u = w_div_zero ? 32'd0  : A / B;
    assign w_rem_u  = w_div_zero ? 32'd0  : A % B;

    always_comb begin
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (flush) begin
            // Cancels the in-flight op and blocks any same-edge completion or issue.
            cnt_d     = 4'd0;
            pend_hi_d = 32'd0;
            pend_lo_d = 32'd0;
        end else if (w_busy) begin
            if (cnt_q == 4'd1) begin
                hi_d  = pend_hi_q;
                lo_d  = pend_lo_q;
                cnt_d = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (start) begin
            case (md_op)
                c_op_mult: begin
                    pend_hi_d = w_prod_s[63:32];
                    pend_lo_d = w_prod_s[31:0];
                    cnt_d     = c_mult_cnt;
                end
                c_op_multu: begin
                    pend_hi_d = w_prod_u[63:32];
                    pend_lo_d = w_prod_u[31:0];
                    cnt_d     = c_mult_cnt;
                end
                c_op_div: begin
                    pend_hi_d = w_div_zero ? hi_q : w_rem_s;
                    pend_lo_d = w_div_zero ? lo_q : w_quot_s;
                    cnt_d     = c_div_cnt;
                end
                c_op_divu: begin
                    pend_hi_d = w_div_zero ? hi_q : w_rem_u;
                    pend_lo_d = w_div_zero ? lo_q : w_quot_u;
                    cnt_d     = c_div_cnt;
                end
                c_op_mthi: hi_d = A;
                c_op_mtlo: lo_d = A;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = w_busy;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign stall_md = md_in_D & (w_busy | (start & w_is_muldiv));

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sched
// Purpose  : Directed plus randomized checks of md_sched against a
//            timestamp-based HI/LO reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        md_in_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
        .flush(flush), .md_in_D(md_in_D), .busy(busy), .hi(hi), .lo(lo),
        .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: an op issued at edge count E retires at edge E+N.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_act;
    int          m_cyc, m_end;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_act = 0; m_end = 0;
    endtask

    task automatic model_edge(input bit st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b, input bit fl);
        longint          ps;
        longint unsigned pu;
        int              n;
        m_cyc++;
        if (fl) begin
            m_act = 0;
        end else if (m_act) begin
            if (m_cyc == m_end) begin
                m_hi  = m_phi;
                m_lo  = m_plo;
                m_act = 0;
            end
        end else if (st) begin
            n = 0;
            case (op)
                3'd1: begin
                    ps = longint'($signed(a)) * longint'($signed(b));
                    m_phi = ps[63:32]; m_plo = ps[31:0]; n = MC;
                end
                3'd2: begin
                    pu = longint'({32'd0, a}) * longint'({32'd0, b});
                    m_phi = pu[63:32]; m_plo = pu[31:0]; n = MC;
                end
                3'd3: begin
                    if (b == 0) begin m_phi = m_hi; m_plo = m_lo; end
                    else begin
                        m_plo = $signed(a) / $signed(b);
                        m_phi = $signed(a) % $signed(b);
                    end
                    n = DC;
                end
                3'd4: begin
                    if (b == 0) begin m_phi = m_hi; m_plo = m_lo; end
                    else begin m_plo = a / b; m_phi = a % b; end
                    n = DC;
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
            if (n > 0) begin
                m_end = m_cyc + n;
                m_act = 1;
            end
        end
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance model at the edge.
    task automatic step(input bit st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit fl, input bit md);
        start = st; md_op = op; A = a; B = b; flush = fl; md_in_D = md;
        #1;
        chk1("busy", busy, m_act);
        chk32("hi", hi, m_hi);
        chk32("lo", lo, m_lo);
        chk1("stall_md", stall_md, md & (m_act | (st && op >= 3'd1 && op <= 3'd4)));
        if (st && m_act && op != 3'd0 && op != 3'd7)
            $display("[TB] note: start issued while busy (protocol violation, expected to be ignored)");
        @(posedge clk);
        model_edge(st, op, a, b, fl);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit md);
        for (int i = 0; i < n; i++) step(0, 3'd0, 32'd0, 32'd0, 0, md);
    endtask

    initial begin
        bit          st, fl, md;
        logic [2:0]  op;
        logic [31:0] a, b;

        reset = 1'b0; start = 0; md_op = 0; A = 0; B = 0; flush = 0; md_in_D = 0;
        m_cyc = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk1("reset_busy", busy, 1'b0);
        chk32("reset_hi", hi, 32'd0);
        chk32("reset_lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // mult -2 * 3 with a dependent instruction in D throughout
        step(1, 3'd1, 32'hFFFFFFFE, 32'd3, 0, 1);
        idle(MC, 1);
        step(0, 3'd0, 32'd0, 32'd0, 0, 1);
        chk32("mult_hi", hi, 32'hFFFFFFFF);
        chk32("mult_lo", lo, 32'hFFFFFFFA);

        step(1, 3'd2, 32'hFFFFFFFE, 32'd3, 0, 0);
        idle(MC, 0);
        chk32("multu_hi", hi, 32'h00000002);
        chk32("multu_lo", lo, 32'hFFFFFFFA);

        step(1, 3'd3, 32'hFFFFFFF9, 32'd2, 0, 0);
        idle(DC, 0);
        chk32("div_hi", hi, 32'hFFFFFFFF);
        chk32("div_lo", lo, 32'hFFFFFFFD);

        step(1, 3'd4, 32'd7, 32'd0, 0, 0);
        idle(DC, 0);
        chk1("divu0_busy", busy, 1'b0);
        chk32("divu0_hi", hi, 32'hFFFFFFFF);
        chk32("divu0_lo", lo, 32'hFFFFFFFD);

        step(1, 3'd5, 32'h12345678, 32'd0, 0, 0);
        step(1, 3'd6, 32'h9ABCDEF0, 32'd0, 0, 0);
        step(0, 3'd0, 32'd0, 32'd0, 0, 0);
        chk32("mthi_hi", hi, 32'h12345678);
        chk32("mtlo_lo", lo, 32'h9ABCDEF0);

        // flush on the 3rd busy cycle of a div
        step(1, 3'd3, 32'd100, 32'd7, 0, 0);
        idle(2, 0);
        step(0, 3'd0, 32'd0, 32'd0, 1, 0);
        chk1("flush_busy", busy, 1'b0);
        chk32("flush_hi", hi, 32'h12345678);
        chk32("flush_lo", lo, 32'h9ABCDEF0);

        // flush coinciding with the completion edge of a mult
        step(1, 3'd1, 32'd3, 32'd3, 0, 0);
        idle(MC - 1, 0);
        step(0, 3'd0, 32'd0, 32'd0, 1, 0);
        chk1("flushc_busy", busy, 1'b0);
        chk32("flushc_lo", lo, 32'h9ABCDEF0);

        // async reset during busy cycle 2
        step(1, 3'd1, 32'd9, 32'd9, 0, 0);
        step(0, 3'd0, 32'd0, 32'd0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk1("rst_mid_busy", busy, 1'b0);
        chk32("rst_mid_hi", hi, 32'd0);
        chk32("rst_mid_lo", lo, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // start while busy is ignored
        step(1, 3'd1, 32'd2, 32'd3, 0, 0);
        step(1, 3'd3, 32'd50, 32'd5, 0, 0);
        idle(MC, 0);
        chk1("ign_busy", busy, 1'b0);
        chk32("ign_hi", hi, 32'd0);
        chk32("ign_lo", lo, 32'd6);

        // randomized traffic that respects the D-stage stall
        for (int i = 0; i < 400; i++) begin
            op = 3'($urandom_range(0, 7));
            st = !m_act && ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 24) == 0);
            md = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            step(st, op, a, b, fl, md);
        end
        idle(DC + 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
